burst_priority_scheduler: RTL and testbench

- Shares one resource (bus or memory port) between N requesters.
- One requester is marked high-priority with a one-hot `priv` vector; the rest are served round-robin.
- A grant is held for a whole burst. It ends when the resource signals `done`, when the owner drops `req`, or when a hold timeout expires.
- Sits between the requester ports and the shared datapath, as the stateful successor to the plain priority arbiter.

---
 rtl/burst_sched_pkg.sv | 23 ++
 rtl/burst_priority_scheduler_rr_picker.sv | 42 ++++
 rtl/burst_priority_scheduler.sv | 176 +++++++++++++++++
 tb/tb_burst_priority_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_sched_pkg.sv
// ---------------------------------------------------------------------------
// burst_sched_pkg
// Shared types and helpers for burst_priority_scheduler and rr_picker.
//   state_t        : scheduler FSM states (ST_IDLE, ST_GRANT, ST_GAP)
//   MAX_N          : widest requester vector supported (16)
//   lowest_onehot  : isolates the lowest set bit of a vector (0 stays 0)
// ---------------------------------------------------------------------------
package burst_sched_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Two's-complement trick: v & -v keeps only the least significant one.
    function automatic logic [MAX_N-1:0] lowest_onehot(input logic [MAX_N-1:0] v);
        return v & (~v + MAX_N'(1));
    endfunction

endpackage

// File: rtl/burst_priority_scheduler_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
// Combinational rotating priority encoder.
//   req  [N] : candidate requests
//   last [N] : one-hot position of the previous round-robin winner
//   pick [N] : one-hot first set req bit searching upward from last+1 with
//              wrap; zero when req is zero
// ---------------------------------------------------------------------------
module rr_picker
    import burst_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] last,
    output logic [N-1:0] pick
);

    // above[i] is set for every position strictly above the last winner.
    logic [N-1:0] above;
    logic [N-1:0] upper;
    logic         unused_last_top;

    assign above[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < N; gi++) begin : g_above
            assign above[gi] = |last[gi-1:0];
        end
    endgenerate

    // The top position has nothing above it, so it never widens the mask.
    assign unused_last_top = last[N-1];

    assign upper = req & above;

    // Requests above the last winner win first; otherwise wrap to the
    // lowest request overall (which may be the last winner itself).
    assign pick = (upper != '0) ? N'(lowest_onehot(MAX_N'(upper)))
                                : N'(lowest_onehot(MAX_N'(req)));

endmodule

// File: rtl/burst_priority_scheduler.sv
// ---------------------------------------------------------------------------
// burst_priority_scheduler
// Shares one resource between N requesters. The requester selected by the
// one-hot priv vector wins arbitration when it requests; the others are
// served round-robin. A grant lasts for a whole burst and ends on done, on
// the owner dropping req, or after MAX_HOLD cycles. Every burst is followed
// by one GAP turnaround cycle.
//
// Parameters: N (2..16), MAX_HOLD (1..255), STARVE_LIMIT (>=1)
// Ports:
//   clk      in  : rising-edge clock
//   reset    in  : synchronous active-high reset
//   req      in  : per-requester request level [N]
//   priv     in  : priority requester select, lowest set bit used [N]
//   done     in  : end of current burst, looked at only in GRANT
//   grant    out : registered one-hot grant [N]
//   vld      out : |grant
//   timeout  out : one-cycle pulse after a burst cut off purely by MAX_HOLD
//
// Build option: define BURST_SCHED_STARVE_GUARD_EN to add a starve counter
// that forces one round-robin arbitration after STARVE_LIMIT consecutive
// priv wins taken while other requesters were waiting.
// ---------------------------------------------------------------------------
module burst_priority_scheduler
    import burst_sched_pkg::*;
#(
    parameter int N            = 4,
    parameter int MAX_HOLD     = 8,
    parameter int STARVE_LIMIT = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] priv,
    input  logic         done,
    output logic [N-1:0] grant,
    output logic         vld,
    output logic         timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    state_t              state_reg,   state_next;
    logic [N-1:0]        grant_reg,   grant_next;
    logic [N-1:0]        last_reg,    last_next;
    logic [HOLD_W-1:0]   hold_reg,    hold_next;
    logic                timeout_reg, timeout_next;

    logic [N-1:0]        priv_oh;
    logic [N-1:0]        priv_hit;
    logic [N-1:0]        others;
    logic [N-1:0]        rr_pick;
    logic                use_priv;
    logic                owner_drop;
    logic                at_limit;

    // A multi-hot priv is reduced to its lowest bit; zero means no priority.
    assign priv_oh  = N'(lowest_onehot(MAX_N'(priv)));
    assign priv_hit = req & priv_oh;
    // When priv is not requesting this equals req, so one picker serves both
    // the plain round-robin case and the starve-guard override.
    assign others   = req & ~priv_oh;

    rr_picker #(
        .N (N)
    ) u_rr_picker (
        .req  (others),
        .last (last_reg),
        .pick (rr_pick)
    );

`ifdef BURST_SCHED_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_reg, starve_next;
    logic                starve_block;

    assign starve_block = (starve_reg == STARVE_W'(STARVE_LIMIT));
    // Priv is skipped only if someone else is actually waiting; otherwise it
    // still gets the resource rather than leaving it idle.
    assign use_priv     = (priv_hit != '0) && !(starve_block && (others != '0));

    always_comb begin
        starve_next = starve_reg;
        if (state_reg == ST_IDLE && req != '0) begin
            if (!use_priv) begin
                starve_next = '0;
            end else if (others != '0 && !starve_block) begin
                starve_next = starve_reg + STARVE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_reg <= '0;
        end else begin
            starve_reg <= starve_next;
        end
    end
`else
    logic unused_starve_cfg;

    assign use_priv          = (priv_hit != '0);
    assign unused_starve_cfg = ^32'(STARVE_LIMIT);
`endif

    assign owner_drop = ((req & grant_reg) == '0);
    assign at_limit   = (hold_reg == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_next   = state_reg;
        grant_next   = grant_reg;
        last_next    = last_reg;
        hold_next    = hold_reg;
        timeout_next = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (req != '0) begin
                    grant_next = use_priv ? priv_hit : rr_pick;
                    // Only round-robin wins move the rotation pointer.
                    if (!use_priv) begin
                        last_next = rr_pick;
                    end
                    hold_next  = '0;
                    state_next = ST_GRANT;
                end
            end

            ST_GRANT: begin
                if (done || owner_drop || at_limit) begin
                    grant_next   = '0;
                    state_next   = ST_GAP;
                    // Pulse only when the hold limit alone ended the burst.
                    timeout_next = at_limit && !done && !owner_drop;
                end else begin
                    hold_next = hold_reg + HOLD_W'(1);
                end
            end

            ST_GAP: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end

            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            grant_reg   <= '0;
            // Last winner at the top bit so the first search starts at bit 0.
            last_reg    <= {1'b1, {(N-1){1'b0}}};
            hold_reg    <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            grant_reg   <= grant_next;
            last_reg    <= last_next;
            hold_reg    <= hold_next;
            timeout_reg <= timeout_next;
        end
    end

    assign grant   = grant_reg;
    assign vld     = |grant_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_burst_priority_scheduler.sv
module tb_burst_priority_scheduler;

    localparam int N            = 4;
    localparam int MAX_HOLD     = 8;
    localparam int STARVE_LIMIT = 3;

`ifdef BURST_SCHED_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] priv;
    logic         done;
    logic [N-1:0] grant;
    logic         vld;
    logic         timeout;

    always #5 clk = ~clk;

    burst_priority_scheduler #(
        .N            (N),
        .MAX_HOLD     (MAX_HOLD),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .priv    (priv),
        .done    (done),
        .grant   (grant),
        .vld     (vld),
        .timeout (timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0 = waiting, 1 = burst in progress, 2 = turnaround.
    int           m_phase;
    int           m_owner;
    int           m_hold;
    int           m_last;
    int           m_starve;
    logic [N-1:0] m_grant;
    logic         m_timeout;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Applies the scheduling rules for one rising edge using current inputs.
    task automatic model_edge();
        if (reset) begin
            m_phase   = 0;
            m_grant   = '0;
            m_timeout = 1'b0;
            m_hold    = 0;
            m_last    = N - 1;
            m_starve  = 0;
        end else begin
            case (m_phase)
                0: begin
                    int           p;
                    int           win;
                    logic [N-1:0] oth;
                    p         = -1;
                    win       = -1;
                    m_timeout = 1'b0;
                    m_grant   = '0;
                    if (req != '0) begin
                        for (int i = 0; i < N; i++) begin
                            if (p < 0 && priv[i]) p = i;
                        end
                        oth = req;
                        if (p >= 0) oth[p] = 1'b0;
                        if (p >= 0 && req[p] &&
                            !(GUARD && m_starve == STARVE_LIMIT && oth != '0)) begin
                            win = p;
                            if (oth != '0 && m_starve < STARVE_LIMIT) m_starve++;
                        end else begin
                            for (int k = 1; k <= N; k++) begin
                                if (win < 0 && oth[(m_last + k) % N]) win = (m_last + k) % N;
                            end
                            m_last   = win;
                            m_starve = 0;
                        end
                        m_owner = win;
                        m_grant = N'(1) << win;
                        m_hold  = 0;
                        m_phase = 1;
                    end
                end
                1: begin
                    logic lim;
                    logic drop;
                    lim       = (m_hold == MAX_HOLD - 1);
                    drop      = !req[m_owner];
                    m_timeout = 1'b0;
                    if (done || drop || lim) begin
                        m_timeout = lim && !done && !drop;
                        m_grant   = '0;
                        m_phase   = 2;
                    end else begin
                        m_hold++;
                    end
                end
                default: begin
                    m_phase   = 0;
                    m_grant   = '0;
                    m_timeout = 1'b0;
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("grant", 32'(grant), 32'(m_grant));
        check_eq("vld", 32'(vld), 32'(m_grant != '0));
        check_eq("timeout", 32'(timeout), 32'(m_timeout));
    endtask

    task automatic wait_any_grant();
        int k;
        k = 0;
        while (grant == '0 && k < 20) begin
            step();
            k++;
        end
        check_eq("wait_grant", 32'(grant != '0), 32'(1));
    endtask

    task automatic wait_grant_of(input logic [N-1:0] want);
        int k;
        k = 0;
        while (grant != want && k < 30) begin
            step();
            k++;
        end
        check_eq("wait_grant_of", 32'(grant), 32'(want));
    endtask

    logic [N-1:0] rot_exp    [4];
    logic [N-1:0] starve_exp [5];
    int           cnt;

    initial begin
        rot_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        if (GUARD) starve_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0010, 4'b0100};
        else       starve_exp = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};

        // Reset with all requests active: no grant may appear.
        reset = 1'b1; req = 4'hF; priv = '0; done = 1'b0;
        #1;
        step();
        check_eq("rst_grant", 32'(grant), 32'(0));
        step();
        check_eq("rst_vld", 32'(vld), 32'(0));

        // First arbitration, then round-robin rotation with 1-cycle bursts.
        reset = 1'b0; done = 1'b1;
        step();
        check_eq("first_rr", 32'(grant), 32'(4'b0001));
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rr_gap1", 32'(grant), 32'(0));
            step();
            check_eq("rr_gap2", 32'(grant), 32'(0));
            step();
            check_eq("rr_rot", 32'(grant), 32'(rot_exp[i]));
        end

        // Priority requester held to the hold limit.
        done = 1'b0; priv = 4'b0100; req = 4'hE;
        wait_grant_of(4'b0100);
        cnt = 0;
        while (grant == 4'b0100 && cnt < 20) begin
            cnt++;
            step();
        end
        check_eq("burst_len", 32'(cnt), 32'(MAX_HOLD));
        check_eq("timeout_pulse", 32'(timeout), 32'(1));
        step();
        check_eq("timeout_once", 32'(timeout), 32'(0));

        // Owner 1 drops req on its third grant cycle.
        priv = '0; req = 4'b0010;
        wait_grant_of(4'b0010);
        step();
        step();
        req = 4'b0000;
        step();
        check_eq("early_clear", 32'(grant), 32'(0));
        check_eq("early_no_to", 32'(timeout), 32'(0));
        req = 4'b0010;
        step();
        check_eq("early_gap", 32'(grant), 32'(0));
        step();
        check_eq("early_regrant", 32'(grant), 32'(4'b0010));

        // Priv against a waiting requester (starve guard when built in).
        reset = 1'b1;
        step();
        reset = 1'b0; priv = 4'b0100; req = 4'b0110; done = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_any_grant();
            check_eq("starve_seq", 32'(grant), 32'(starve_exp[i]));
            step();
        end

        // Reset in the middle of a burst.
        priv = '0; req = 4'hF; done = 1'b0;
        wait_any_grant();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("midrst_grant", 32'(grant), 32'(0));
        reset = 1'b0;
        step();
        check_eq("post_rst_rr", 32'(grant), 32'(4'b0001));

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            case ($urandom_range(0, 2))
                0:       priv = '0;
                1:       priv = 4'(1) << $urandom_range(0, N - 1);
                default: priv = 4'($urandom);
            endcase
            done = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
